deskew_collector: RTL and testbench

- Read-side counterpart to the input skew delay lines that feed the systolic array.
- Takes DIM staggered result lanes off the array edge, where lane i lags lane 0 by i advance strobes.
- Re-aligns the lanes into whole rows, buffers one tile of ROWS rows, and hands rows out over valid/ready toward the CCI-P write path.

---
 rtl/deskew_pkg.sv | 29 ++
 rtl/lane_delay.sv | 51 +++++
 rtl/deskew_collector.sv | 185 ++++++++++++++++++
 tb/tb_deskew_collector.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/deskew_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deskew_pkg: shared state encoding and sizing helpers for the         |
// | deskew collector.                                                    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package deskew_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Extra MSB distinguishes full from empty when indices match.
  function automatic int ptr_width(input int rows);
    return $clog2(rows) + 1;
  endfunction

  function automatic int row_width(input int dim, input int bits);
    return dim * bits;
  endfunction

  function automatic int lane_lsb(input int lane, input int bits);
    return lane * bits;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lane_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lane_delay: DEPTH-stage enable-gated delay line, DEPTH=0 is a wire.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module lane_delay #(
  parameter int DEPTH = 1,
  parameter int BITS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_passthru
      logic unused_ok;
      assign unused_ok = ^{clk, rst, en};
      assign q         = d;
    end else begin : g_shift
      logic [BITS-1:0] stage_q [DEPTH];
      logic [BITS-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d = stage_q;
        if (en) begin
          stage_d[0] = d;
          for (int s = 1; s < DEPTH; s++) begin
            stage_d[s] = stage_q[s-1];
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int s = 0; s < DEPTH; s++) begin
            stage_q[s] <= '0;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/deskew_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | deskew_collector: re-aligns DIM skewed array lanes into rows, buffers|
// | one tile and streams rows out over valid/ready.                      |
// | Optional: DESKEW_STALL_CNT_EN adds the stall_cycles counter output.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module deskew_collector #(
  parameter int DIM  = 8,
  parameter int BITS = 64,
  parameter int ROWS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    in_en,
  input  logic [DIM*BITS-1:0]     in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIM*BITS-1:0]     out_row,
  output logic [$clog2(ROWS)-1:0] out_idx,
  output logic                    busy,
  output logic                    done
`ifdef DESKEW_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cycles
`endif
);
  import deskew_pkg::*;

  localparam int PW = ptr_width(ROWS);
  localparam int AW = PW - 1;
  localparam int RW = row_width(DIM, BITS);
  localparam int EW = $clog2(DIM + ROWS) + 1;
  localparam int WW = $clog2(ROWS + 1);

  state_e          state_q, state_d;
  logic [EW-1:0]   ecnt_q, ecnt_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [RW-1:0]   mem_q [ROWS];
  logic [RW-1:0]   mem_d [ROWS];
  logic            done_q, done_d;
  logic [RW-1:0]   aligned_row;
  logic            start_ok;
  logic            wr_en;
  logic            rd_en;
  logic            empty;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p[AW-1:0] == AW'(ROWS - 1)) begin
      return {~p[PW-1], {AW{1'b0}}};
    end
    return p + PW'(1);
  endfunction

  // Lane i waits DIM-1-i strobes so every lane lands on the same row.
  generate
    for (genvar i = 0; i < DIM; i++) begin : g_lane
      lane_delay #(
        .DEPTH (DIM - 1 - i),
        .BITS  (BITS)
      ) u_lane_delay (
        .clk (clk),
        .rst (rst),
        .en  (in_en),
        .d   (in_data[lane_lsb(i, BITS) +: BITS]),
        .q   (aligned_row[lane_lsb(i, BITS) +: BITS])
      );
    end
  endgenerate

  assign empty    = (wptr_q == rptr_q);
  assign rd_en    = !empty && out_ready;
  assign start_ok = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    ecnt_d  = ecnt_q;
    wcnt_d  = wcnt_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;

    if (rd_en) begin
      rptr_d = ptr_inc(rptr_q);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FILL;
          ecnt_d  = '0;
          wcnt_d  = '0;
          wptr_d  = '0;
          rptr_d  = '0;
        end
      end
      FILL: begin
        if (in_en) begin
          ecnt_d = ecnt_q + EW'(1);
          // Strobes before DIM-1 only prime the delay lines.
          if (ecnt_q >= EW'(DIM - 1)) begin
            wr_en  = 1'b1;
            wcnt_d = wcnt_q + WW'(1);
            if (wcnt_d == WW'(ROWS)) begin
              state_d = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        if (rd_en && (rptr_q[AW-1:0] == AW'(ROWS - 1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) begin
      mem_d[wptr_q[AW-1:0]] = aligned_row;
      wptr_d                = ptr_inc(wptr_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ecnt_q  <= '0;
      wcnt_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      done_q  <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        mem_q[r] <= '0;
      end
    end else begin
      state_q <= state_d;
      ecnt_q  <= ecnt_d;
      wcnt_q  <= wcnt_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  assign out_valid = !empty;
  assign out_row   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign out_idx   = rptr_q[AW-1:0];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

`ifdef DESKEW_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if (busy && out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_deskew_collector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_deskew_collector: scoreboard bench for deskew_collector           |
// | (DIM=4, BITS=8, ROWS=4). Honours DESKEW_STALL_CNT_EN when defined.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_deskew_collector;

  localparam int DIM  = 4;
  localparam int BITS = 8;
  localparam int ROWS = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 in_en;
  logic [DIM*BITS-1:0]  in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DIM*BITS-1:0]  out_row;
  logic [1:0]           out_idx;
  logic                 busy;
  logic                 done;
`ifdef DESKEW_STALL_CNT_EN
  logic [31:0]          stall_cycles;
`endif

  deskew_collector #(
    .DIM  (DIM),
    .BITS (BITS),
    .ROWS (ROWS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_en        (in_en),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_row      (out_row),
    .out_idx      (out_idx),
    .busy         (busy),
    .done         (done)
`ifdef DESKEW_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] row;
    logic [1:0]  idx;
  } exp_t;

  exp_t sb[$];
  int   checks     = 0;
  int   failures   = 0;
  int   done_seen  = 0;
  int   pops       = 0;
  int   k_cnt      = 0;
  int   pushed     = 0;
  bit   busy_exp   = 1'b0;
  bit   done_exp   = 1'b0;
  bit   busy_nxt;
  bit   done_nxt;

  function automatic logic [31:0] row_val(input int r);
    logic [31:0] v;
    for (int i = 0; i < DIM; i++) begin
      v[i*BITS +: BITS] = 8'(16 * r + i);
    end
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Compares outputs against the scoreboard head; pops on handshake.
  task automatic mon();
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("busy", 32'(busy), 32'(busy_exp));
    chk("done", 32'(done), 32'(done_exp));
    if (done === 1'b1) done_seen++;
    busy_nxt = busy_exp;
    done_nxt = 1'b0;
    if (sb.size() != 0) begin
      chk("out_row", out_row, sb[0].row);
      chk("out_idx", 32'(out_idx), 32'(sb[0].idx));
      if (out_ready) begin
        void'(sb.pop_front());
        pops++;
        if (sb.size() == 0 && pushed == ROWS) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
        end
      end
    end
  endtask

  task automatic cyc(input bit st, input bit en, input logic [31:0] d, input bit rdy, input bit rs);
    rst       = rs;
    start     = st;
    in_en     = en;
    in_data   = d;
    out_ready = rdy;
    @(negedge clk);
    mon();
    if (rs) begin
      busy_nxt = 1'b0;
      done_nxt = 1'b0;
    end else if (st && !busy_exp) begin
      busy_nxt = 1'b1;
      k_cnt    = 0;
      pushed   = 0;
    end
    @(posedge clk);
    #1;
    busy_exp = busy_nxt;
    done_exp = done_nxt;
    if (rs) sb.delete();
  endtask

  // One counted strobe: lane i carries row k-i (junk outside the tile).
  task automatic strobe(input bit rdy);
    logic [31:0] d;
    int          r;
    for (int i = 0; i < DIM; i++) begin
      r = k_cnt - i;
      if (r >= 0 && r < ROWS) d[i*BITS +: BITS] = 8'(16 * r + i);
      else                    d[i*BITS +: BITS] = 8'($urandom);
    end
    cyc(1'b0, 1'b1, d, rdy, 1'b0);
    if (k_cnt >= DIM - 1) begin
      sb.push_back(exp_t'{row: row_val(k_cnt - DIM + 1), idx: 2'(k_cnt - DIM + 1)});
      pushed++;
    end
    k_cnt++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || done_exp || busy_exp) && n < budget) begin
      cyc(1'b0, 1'b0, $urandom, 1'b1, 1'b0);
      n++;
    end
    chk("drain_bound", 32'(sb.size() != 0 || busy_exp), 32'd0);
  endtask

  task automatic ramp_tile(input string tag);
    done_seen = 0;
    pops      = 0;
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < ROWS + DIM - 1; j++) strobe(1'b1);
    drain(30);
    chk({tag, "_done_cnt"}, 32'(done_seen), 32'd1);
    chk({tag, "_rows"}, 32'(pops), 32'(ROWS));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; in_en = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(done),      32'd0);
    chk("rst_row",   out_row,        32'd0);
    chk("rst_idx",   32'(out_idx),   32'd0);

    // Skewed ramp, consumer always ready.
    ramp_tile("ramp");

    // Gapped strobes: one in three cycles.
    done_seen = 0;
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < ROWS + DIM - 1; j++) begin
      strobe(1'b1);
      if (j == DIM - 1) chk("gap_first_valid", 32'(out_valid), 32'd1);
      if (j < ROWS + DIM - 2) begin
        cyc(1'b0, 1'b0, $urandom, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, $urandom, 1'b1, 1'b0);
      end
    end
    drain(30);
    chk("gap_done_cnt", 32'(done_seen), 32'd1);

    // Back-pressure across the whole fill, then release.
    done_seen = 0;
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int j = 0; j < ROWS + DIM - 1; j++) strobe(1'b0);
    chk("hold_row", out_row, 32'h0302_0100);
    chk("hold_idx", 32'(out_idx), 32'd0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("hold_row2", out_row, 32'h0302_0100);
    drain(30);
    chk("hold_done_cnt", 32'(done_seen), 32'd1);

    // Second start mid-fill is ignored.
    done_seen = 0;
    pops      = 0;
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < 3; j++) strobe(1'b1);
    cyc(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    for (int j = 3; j < ROWS + DIM - 1; j++) strobe(1'b1);
    drain(30);
    chk("restart_rows", 32'(pops), 32'(ROWS));
    chk("restart_done_cnt", 32'(done_seen), 32'd1);

    // Reset after two rows are buffered.
    done_seen = 0;
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int j = 0; j < DIM + 1; j++) strobe(1'b0);
    chk("prerst_valid", 32'(out_valid), 32'd1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("postrst_valid", 32'(out_valid), 32'd0);
    chk("postrst_busy",  32'(busy),      32'd0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("postrst_done_cnt", 32'(done_seen), 32'd0);
    ramp_tile("after_rst");

`ifdef DESKEW_STALL_CNT_EN
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int j = 0; j < DIM; j++) strobe(1'b0);
    repeat (5) cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    chk("stall_count", stall_cycles, 32'd5);
    for (int j = DIM; j < ROWS + DIM - 1; j++) strobe(1'b1);
    drain(30);
    chk("stall_kept", stall_cycles, 32'd5);
    cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("stall_clear", stall_cycles, 32'd0);
    for (int j = 0; j < ROWS + DIM - 1; j++) strobe(1'b1);
    drain(30);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
